// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives an 8-bit two-slice ALU for 8/16-bit commands.
// Wide commands run low byte then high byte with the carry chained.
module alu_op_sequencer #(
  parameter bit CARRY_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [3:0]  cmd_sel,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_wide,
  input  logic        cmd_cin,
  input  logic        cmd_use_cf,
  output logic        alu_mode,
  output logic [3:0]  alu_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_f,
  input  logic        alu_cout,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_f,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        carry_flag,
  output logic        zero_flag
);

  // Pin-level value that means "no carry".
  localparam logic CINV = CARRY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_mode;
  logic [3:0]  r_sel;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_wide;
  logic [7:0]  r_f_lo;
  logic        r_z_lo;
  logic        r_cmd_ready;
  logic        r_alu_mode;
  logic [3:0]  r_alu_sel;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic        r_alu_cin;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_f;
  logic        r_rsp_carry;
  logic        r_rsp_zero;
  logic        r_carry_flag;
  logic        r_zero_flag;

  logic w_cout;
  logic w_cin_lo;

  // Carry-out normalised to active-high; low-pass carry-in selection.
  assign w_cout   = alu_cout ^ CINV;
  assign w_cin_lo = cmd_use_cf ? r_carry_flag : cmd_cin;

  // Sequencer FSM; every output is registered and set on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_sel        <= 4'h0;
      r_a          <= 16'h0000;
      r_b          <= 16'h0000;
      r_wide       <= 1'b0;
      r_f_lo       <= 8'h00;
      r_z_lo       <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_alu_mode   <= 1'b1;
      r_alu_sel    <= 4'h0;
      r_alu_a      <= 8'h00;
      r_alu_b      <= 8'h00;
      r_alu_cin    <= CINV;
      r_rsp_valid  <= 1'b0;
      r_rsp_f      <= 16'h0000;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_carry_flag <= 1'b0;
      r_zero_flag  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_mode      <= cmd_mode;
            r_sel       <= cmd_sel;
            r_a         <= cmd_a;
            r_b         <= cmd_b;
            r_wide      <= cmd_wide;
            r_cmd_ready <= 1'b0;
            r_alu_mode  <= cmd_mode;
            r_alu_sel   <= cmd_sel;
            r_alu_a     <= cmd_a[7:0];
            r_alu_b     <= cmd_b[7:0];
            r_alu_cin   <= w_cin_lo ^ CINV;
            r_state     <= S_LO;
          end
        end
        S_LO: begin
          r_f_lo <= alu_f;
          r_z_lo <= alu_zero;
          if (r_wide) begin
            r_alu_mode <= r_mode;
            r_alu_sel  <= r_sel;
            r_alu_a    <= r_a[15:8];
            r_alu_b    <= r_b[15:8];
            r_alu_cin  <= w_cout ^ CINV;
            r_state    <= S_HI;
          end else begin
            r_rsp_f     <= {8'h00, alu_f};
            r_rsp_carry <= w_cout;
            r_rsp_zero  <= alu_zero;
            r_zero_flag <= alu_zero;
            if (!r_mode) r_carry_flag <= w_cout;
            r_rsp_valid <= 1'b1;
            r_alu_mode  <= 1'b1;
            r_alu_sel   <= 4'h0;
            r_alu_a     <= 8'h00;
            r_alu_b     <= 8'h00;
            r_alu_cin   <= CINV;
            r_state     <= S_RESP;
          end
        end
        S_HI: begin
          r_rsp_f     <= {alu_f, r_f_lo};
          r_rsp_carry <= w_cout;
          r_rsp_zero  <= r_z_lo & alu_zero;
          r_zero_flag <= r_z_lo & alu_zero;
          if (!r_mode) r_carry_flag <= w_cout;
          r_rsp_valid <= 1'b1;
          r_alu_mode  <= 1'b1;
          r_alu_sel   <= 4'h0;
          r_alu_a     <= 8'h00;
          r_alu_b     <= 8'h00;
          r_alu_cin   <= CINV;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign alu_mode   = r_alu_mode;
  assign alu_sel    = r_alu_sel;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cin    = r_alu_cin;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_f      = r_rsp_f;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_zero   = r_rsp_zero;
  assign carry_flag = r_carry_flag;
  assign zero_flag  = r_zero_flag;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vectors against a behavioural 74181 model.
// ALU carry pins are active-low, as with the default parameter.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [3:0]  cmd_sel = 4'h0;
  logic [15:0] cmd_a = 16'h0;
  logic [15:0] cmd_b = 16'h0;
  logic        cmd_wide = 1'b0;
  logic        cmd_cin = 1'b0;
  logic        cmd_use_cf = 1'b0;
  logic        alu_mode;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_f;
  logic        alu_cout;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_f;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        carry_flag;
  logic        zero_flag;

  int errs = 0;
  int checks = 0;

  alu_op_sequencer #(.CARRY_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_wide(cmd_wide), .cmd_cin(cmd_cin),
    .cmd_use_cf(cmd_use_cf),
    .alu_mode(alu_mode), .alu_sel(alu_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  always #5 clk = ~clk;

  // ALU model: add (mode 0, sel 1001), xor/and/or/not in logic mode.
  logic [8:0] sum;
  always_comb begin
    sum      = 9'h000;
    alu_f    = 8'h00;
    alu_cout = 1'b1;
    if (!alu_mode) begin
      if (alu_sel == 4'b1001) begin
        sum      = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, ~alu_cin};
        alu_f    = sum[7:0];
        alu_cout = ~sum[8];
      end else begin
        alu_f = alu_a;
      end
    end else begin
      case (alu_sel)
        4'b0110: alu_f = alu_a ^ alu_b;
        4'b1011: alu_f = alu_a & alu_b;
        4'b1110: alu_f = alu_a | alu_b;
        default: alu_f = ~alu_a;
      endcase
    end
    alu_zero = (alu_f == 8'h00);
  end

  typedef struct {
    logic        mode;
    logic [3:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        wide;
    logic        cin;
    logic        ucf;
    logic [15:0] f;
    logic        c;
    logic        z;
    logic        cf;
    logic        zf;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic accept_cmd(input logic m, input logic [3:0] s,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic w, input logic ci,
                            input logic u);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 1);
    cmd_mode   = m;
    cmd_sel    = s;
    cmd_a      = a;
    cmd_b      = b;
    cmd_wide   = w;
    cmd_cin    = ci;
    cmd_use_cf = u;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    accept_cmd(v.mode, v.sel, v.a, v.b, v.wide, v.cin, v.ucf);
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d latency", idx), n, v.wide ? 3 : 2);
    chk($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, 1);
    chk($sformatf("v%0d rsp_f", idx), {16'h0, rsp_f}, {16'h0, v.f});
    chk($sformatf("v%0d rsp_carry", idx), {31'b0, rsp_carry}, {31'b0, v.c});
    chk($sformatf("v%0d rsp_zero", idx), {31'b0, rsp_zero}, {31'b0, v.z});
    chk($sformatf("v%0d carry_flag", idx), {31'b0, carry_flag}, {31'b0, v.cf});
    chk($sformatf("v%0d zero_flag", idx), {31'b0, zero_flag}, {31'b0, v.zf});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk($sformatf("v%0d drop", idx), {31'b0, rsp_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            mode sel     a        b        w  ci u  f        c  z  cf zf
    vt[0] = '{1'b0, 4'b1001, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 4'b1001, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[3] = '{1'b0, 4'b1001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 4'b1001, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[5] = '{1'b1, 4'b0110, 16'h005A, 16'h005A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[6] = '{1'b1, 4'b0110, 16'h00F0, 16'h000F, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7] = '{1'b1, 4'b0110, 16'h1234, 16'h00FF, 1'b1, 1'b0, 1'b0, 16'h12CB, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[8] = '{1'b0, 4'b1001, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1, 16'h0031, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 4'b1001, 16'hAB05, 16'hCD03, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with clocks running.
    repeat (3) @(posedge clk);
    #1;
    chk("rst cmd_ready", {31'b0, cmd_ready}, 1);
    chk("rst rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst rsp_f", {16'h0, rsp_f}, 0);
    chk("rst carry_flag", {31'b0, carry_flag}, 0);
    chk("rst zero_flag", {31'b0, zero_flag}, 0);
    chk("rst alu_cin", {31'b0, alu_cin}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Wide add: ALU drive in LO and HI passes.
    accept_cmd(1'b0, 4'b1001, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0);
    chk("lo alu_a", {24'h0, alu_a}, 32'hFF);
    chk("lo alu_b", {24'h0, alu_b}, 32'h01);
    chk("lo alu_cin", {31'b0, alu_cin}, 1);
    @(posedge clk);
    #1;
    chk("hi alu_a", {24'h0, alu_a}, 32'h00);
    chk("hi alu_cin", {31'b0, alu_cin}, 0);
    chk("hi rsp_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk);
    #1;
    chk("hi rsp_f", {16'h0, rsp_f}, 32'h0100);
    chk("resp alu_mode", {31'b0, alu_mode}, 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Backpressure with a second command waiting.
    accept_cmd(1'b0, 4'b1001, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp valid", {31'b0, rsp_valid}, 1);
    cmd_a     = 16'h0011;
    cmd_b     = 16'h0022;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d valid", i), {31'b0, rsp_valid}, 1);
      chk($sformatf("bp%0d rsp_f", i), {16'h0, rsp_f}, 32'h0080);
      chk($sformatf("bp%0d cmd_ready", i), {31'b0, cmd_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp exit valid", {31'b0, rsp_valid}, 0);
    chk("bp exit ready", {31'b0, cmd_ready}, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("bp accept", {31'b0, cmd_ready}, 0);
    @(posedge clk);
    #1;
    chk("bp2 valid", {31'b0, rsp_valid}, 1);
    chk("bp2 rsp_f", {16'h0, rsp_f}, 32'h0033);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Asynchronous reset in the middle of LO.
    run_vec(vt[4], 10);
    accept_cmd(1'b0, 4'b1001, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst cmd_ready", {31'b0, cmd_ready}, 1);
    chk("arst rsp_valid", {31'b0, rsp_valid}, 0);
    chk("arst carry_flag", {31'b0, carry_flag}, 0);
    chk("arst zero_flag", {31'b0, zero_flag}, 0);
    chk("arst alu_a", {24'h0, alu_a}, 0);
    chk("arst alu_cin", {31'b0, alu_cin}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[0], 11);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
